// File: rtl/watch_time_controller.sv
// Watch timekeeping and set-mode controller.
// Keeps hours/minutes/seconds from a 1 Hz tick and lets the user set hours and
// minutes with mode/inc button pulses. Set mode blinks and times out after
// AUTO_EXIT_S ticks without a button press.
module watch_time_controller #(
    parameter int AUTO_EXIT_S = 30
) (
    input  logic       clk_100MHz_i,
    input  logic       reset_n_i,
    input  logic       tick_i,
    input  logic       mode_i,
    input  logic       inc_i,
    output logic [4:0] hours_o,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic [1:0] state_o,
    output logic       blink_o,
    output logic       minute_pulse_o
);

    localparam int IDLE_W = (AUTO_EXIT_S < 1) ? 1 : $clog2(AUTO_EXIT_S + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(AUTO_EXIT_S);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        hours_q, hours_d;
    logic [5:0]        minutes_q, minutes_d;
    logic [5:0]        seconds_q, seconds_d;
    logic              blink_q, blink_d;
    logic              minute_pulse_q, minute_pulse_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [IDLE_W-1:0] idle_inc;

    assign idle_inc = idle_q + 1'b1;

    // Next-state and datapath: time keeping in RUN, button handling and idle timeout in set states.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        hours_d        = hours_q;
        minutes_d      = minutes_q;
        seconds_d      = seconds_q;
        blink_d        = blink_q;
        idle_d         = idle_q;
        minute_pulse_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mode_i) begin
                    // Entering set mode discards a coincident tick.
                    state_d   = ST_SET_HOUR;
                    seconds_d = 6'd0;
                    blink_d   = 1'b1;
                    idle_d    = '0;
                end else if (tick_i) begin
                    if (seconds_q == 6'd59) begin
                        seconds_d      = 6'd0;
                        minute_pulse_d = 1'b1;
                        if (minutes_q == 6'd59) begin
                            minutes_d = 6'd0;
                            hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end
            end
            ST_SET_HOUR: begin
                if (mode_i) begin
                    state_d = ST_SET_MIN;
                    blink_d = 1'b1;
                    idle_d  = '0;
                end else if (inc_i) begin
                    hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                    idle_d  = '0;
                end
            end
            ST_SET_MIN: begin
                if (mode_i) begin
                    state_d = ST_RUN;
                    blink_d = 1'b0;
                    idle_d  = '0;
                end else if (inc_i) begin
                    // Minute setting wraps without carrying into hours.
                    minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                    idle_d    = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                blink_d = 1'b0;
                idle_d  = '0;
            end
        endcase

        // Ticks in set mode only blink and age the idle counter; mode presses take priority.
        if ((state_q == ST_SET_HOUR || state_q == ST_SET_MIN) && tick_i && !mode_i) begin
            blink_d = ~blink_q;
            if (!inc_i && AUTO_EXIT_S > 0) begin
                if (idle_inc == IDLE_MAX) begin
                    state_d = ST_RUN;
                    blink_d = 1'b0;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_100MHz_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n_i) begin
            state_q        <= ST_RUN;
            hours_q        <= 5'd0;
            minutes_q      <= 6'd0;
            seconds_q      <= 6'd0;
            blink_q        <= 1'b0;
            minute_pulse_q <= 1'b0;
            idle_q         <= '0;
        end else begin
            state_q        <= state_d;
            hours_q        <= hours_d;
            minutes_q      <= minutes_d;
            seconds_q      <= seconds_d;
            blink_q        <= blink_d;
            minute_pulse_q <= minute_pulse_d;
            idle_q         <= idle_d;
        end
    end

    assign hours_o        = hours_q;
    assign minutes_o      = minutes_q;
    assign seconds_o      = seconds_q;
    assign state_o        = state_q;
    assign blink_o        = blink_q;
    assign minute_pulse_o = minute_pulse_q;

endmodule

// File: tb/tb_watch_time_controller.sv
// Directed testbench for watch_time_controller (AUTO_EXIT_S = 30).
module tb_watch_time_controller;

    logic       clk_100MHz_i = 1'b0;
    logic       reset_n_i    = 1'b0;
    logic       tick_i       = 1'b0;
    logic       mode_i       = 1'b0;
    logic       inc_i        = 1'b0;
    logic [4:0] hours_o;
    logic [5:0] minutes_o;
    logic [5:0] seconds_o;
    logic [1:0] state_o;
    logic       blink_o;
    logic       minute_pulse_o;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_seen;

    watch_time_controller #(.AUTO_EXIT_S(30)) dut (
        .clk_100MHz_i  (clk_100MHz_i),
        .reset_n_i     (reset_n_i),
        .tick_i        (tick_i),
        .mode_i        (mode_i),
        .inc_i         (inc_i),
        .hours_o       (hours_o),
        .minutes_o     (minutes_o),
        .seconds_o     (seconds_o),
        .state_o       (state_o),
        .blink_o       (blink_o),
        .minute_pulse_o(minute_pulse_o)
    );

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge that consumed them.
    task automatic step(input logic t, input logic m, input logic i);
        tick_i = t;
        mode_i = m;
        inc_i  = i;
        @(posedge clk_100MHz_i);
        #1;
        tick_i = 1'b0;
        mode_i = 1'b0;
        inc_i  = 1'b0;
        pulse_seen += int'(minute_pulse_o);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        reset_n_i = 1'b1;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hours"}, 32'(hours_o), h);
        check({tag, "_minutes"}, 32'(minutes_o), m);
        check({tag, "_seconds"}, 32'(seconds_o), s);
    endtask

    initial begin
        pulse_seen = 0;

        // Reset state (inputs driven high during reset must be ignored)
        do_reset();
        idle(1);
        check_time("reset", 0, 0, 0);
        check("reset_state", 32'(state_o), 0);
        check("reset_blink", 32'(blink_o), 0);
        check("reset_pulse", 32'(minute_pulse_o), 0);

        // 1. Seconds-to-minute rollover, ticks spaced 5 cycles
        pulse_seen = 0;
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k == 1)  check("t1_first_tick", 32'(seconds_o), 1);
            if (k == 59) check_time("t1_at59", 0, 0, 59);
            if (k == 60) begin
                check_time("t1_rollover", 0, 1, 0);
                check("t1_pulse_high", 32'(minute_pulse_o), 1);
            end
            idle(4);
            if (k == 60) check("t1_pulse_low_after", 32'(minute_pulse_o), 0);
        end
        check("t1_pulse_count", 32'(pulse_seen), 1);

        // 2. Setting with wrap, then midnight rollover
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        check("t2_enter_set_hour", 32'(state_o), 1);
        for (int k = 0; k < 23; k++) step(1'b0, 1'b0, 1'b1);
        check("t2_hours_23", 32'(hours_o), 23);
        step(1'b0, 1'b1, 1'b0);
        check("t2_set_min", 32'(state_o), 2);
        for (int k = 0; k < 61; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check_time("t2_after_set", 23, 1, 0);
        check("t2_state_run", 32'(state_o), 0);
        check("t2_blink_run", 32'(blink_o), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 58; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check_time("t2_set_2359", 23, 59, 0);
        pulse_seen = 0;
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k == 59) check_time("t2_235959", 23, 59, 59);
            idle(1);
        end
        check_time("t2_midnight", 0, 0, 0);
        check("t2_pulse_count", 32'(pulse_seen), 1);

        // 3. Blink and ticks in set mode
        step(1'b0, 1'b1, 1'b0);
        check("t3_blink0", 32'(blink_o), 1);
        step(1'b1, 1'b0, 1'b0);
        check("t3_blink1", 32'(blink_o), 0);
        step(1'b1, 1'b0, 1'b0);
        check("t3_blink2", 32'(blink_o), 1);
        step(1'b1, 1'b0, 1'b0);
        check("t3_blink3", 32'(blink_o), 0);
        check_time("t3_frozen", 0, 0, 0);
        check("t3_state", 32'(state_o), 1);
        step(1'b0, 1'b1, 1'b0);
        check("t3_set_min_blink", 32'(blink_o), 1);
        step(1'b0, 1'b1, 1'b0);
        check("t3_back_run", 32'(state_o), 0);

        // 4a. Auto-exit after 30 idle ticks
        step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k == 29) check("t4a_still_set", 32'(state_o), 1);
        end
        check("t4a_exit_state", 32'(state_o), 0);
        check("t4a_exit_blink", 32'(blink_o), 0);
        check_time("t4a_time", 0, 0, 0);

        // 4b. inc on tick 20 restarts the idle count
        step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            step(1'b1, 1'b0, (k == 20));
            if (k == 20) begin
                check("t4b_inc_hours", 32'(hours_o), 1);
                check("t4b_inc_blink", 32'(blink_o), 1);
            end
            if (k == 30) check("t4b_no_exit_30", 32'(state_o), 1);
            if (k == 49) check("t4b_still_set_49", 32'(state_o), 1);
        end
        check("t4b_exit_state", 32'(state_o), 0);
        check_time("t4b_time", 1, 0, 0);

        // 5. Simultaneous events
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("t5_mode_inc_state", 32'(state_o), 2);
        check("t5_mode_inc_hours", 32'(hours_o), 1);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 59; k++) step(1'b1, 1'b0, 1'b0);
        check_time("t5_at59", 1, 0, 59);
        pulse_seen = 0;
        step(1'b1, 1'b1, 1'b0);
        check("t5_tick_mode_state", 32'(state_o), 1);
        check_time("t5_tick_mode_time", 1, 0, 0);
        idle(1);
        check("t5_no_pulse", 32'(pulse_seen), 0);
        for (int k = 0; k < 29; k++) step(1'b1, 1'b0, 1'b0);
        check("t5_idle29_state", 32'(state_o), 1);
        step(1'b1, 1'b1, 1'b0);
        check("t5_mode_beats_exit", 32'(state_o), 2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 23; k++) step(1'b0, 1'b0, 1'b1);
        check("t5_hour_wrap", 32'(hours_o), 0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 42; k++) step(1'b0, 1'b0, 1'b1);
        check_time("t6_pre_reset", 7, 42, 0);
        check("t6_pre_state", 32'(state_o), 2);

        // 6. Reset mid-operation, then first tick honoured
        do_reset();
        check_time("t6_reset", 0, 0, 0);
        check("t6_reset_state", 32'(state_o), 0);
        check("t6_reset_blink", 32'(blink_o), 0);
        check("t6_reset_pulse", 32'(minute_pulse_o), 0);
        step(1'b1, 1'b0, 1'b0);
        check("t6_first_tick", 32'(seconds_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_time_controller.md
# watch_time_controller

Timekeeping and set-mode controller for the watch. Consumes the one-cycle-per-second pulse from the clock divider and maintains the time of day as hours, minutes and seconds. A three-state machine lets the user set hours and minutes from two debounced button pulses. Outputs feed the display/BCD stage and the alarm logic.

## Interface

**Parameters**
- AUTO_EXIT_S, default 30: number of ticks with no button press after which set mode returns to RUN. 0 disables auto-exit.

**Ports**
- clk_100MHz_i  in  1  system clock; one clock domain; all logic on rising edge
- reset_n_i  in  1  reset, synchronous and active-low
- tick_i  in  1  one-cycle pulse per second from the divider
- mode_i  in  1  one-cycle debounced pulse, mode button
- inc_i  in  1  one-cycle debounced pulse, increment button
- hours_o  out  5  hours, binary 0..23
- minutes_o  out  6  minutes, binary 0..59
- seconds_o  out  6  seconds, binary 0..59
- state_o  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN; 3 is never driven
- blink_o  out  1  display blink phase; 0 in RUN
- minute_pulse_o  out  1  one-cycle pulse on each minute rollover in RUN

## Operation

**Reset** (reset_n_i low at a clock edge) clears everything:
- hours, minutes and seconds go to 0.
- State goes to RUN.
- blink_o = 0 and minute_pulse_o = 0.
- The idle counter is cleared.
- Reset overrides all other inputs in the same cycle.

**RUN**
- On tick_i: seconds +1.
- When seconds = 59: seconds → 0, minutes +1, and minute_pulse_o = 1 next cycle.
- When minutes = 59 at the same carry: minutes → 0, hours +1.
- When hours = 23 at the same carry: hours → 0.
- inc_i is ignored.
- On mode_i: go to SET_HOUR.
  - seconds → 0.
  - blink_o → 1.
  - Idle counter → 0.
  - A tick_i in the same cycle is discarded, so no minute pulse is produced.

**SET_HOUR**
- On inc_i: hours +1, wrapping 23 → 0. Idle counter → 0.
- On mode_i: go to SET_MIN. blink_o → 1, idle counter → 0.

**SET_MIN**
- On inc_i: minutes +1, wrapping 59 → 0. There is no carry into hours. Idle counter → 0.
- On mode_i: go to RUN. blink_o → 0, seconds stay 0.

**Behaviour common to both set states**
- tick_i never advances the time.
- Each tick_i toggles blink_o.
- Each tick_i increments the idle counter unless a press occurs in the same cycle.
- Auto-exit (AUTO_EXIT_S > 0): when a tick_i makes the idle count reach AUTO_EXIT_S, go to RUN with blink_o → 0. This takes effect the same cycle as the tick.
- Idle counter width: $clog2(AUTO_EXIT_S+1), minimum 1.

**Simultaneous events**
- mode_i with inc_i: mode wins and the increment is dropped.
- inc_i with tick_i in a set state:
  - The increment is applied.
  - The idle counter is cleared.
  - blink_o still toggles.
- mode_i with an auto-exit tick: mode_i wins.
  - In SET_HOUR, go to SET_MIN.
  - In SET_MIN, go to RUN; the result is the same either way.

**Arithmetic**
- All counters are compared against their exact maximum (23 or 59) before incrementing.
- Out-of-range values are unreachable.

## Timing

- All outputs are registered.
- Latency is 1 cycle from an input pulse at an edge to the updated outputs after that edge.
- minute_pulse_o is high for exactly one cycle. That cycle is the same one in which seconds_o first reads 0 after 59.
- Inputs are assumed to be single-cycle pulses. A pulse held high for N cycles counts as N events; debouncing and edge detection happen upstream.
- Throughput: one event per cycle. Back-to-back inc_i pulses increment on every cycle.
- Reset recovery: the first tick_i after reset_n_i goes high is honoured.

## Test plan

1. **Seconds-to-minute rollover.** Reset, then 60 tick_i pulses spaced 5 cycles apart.
   - Expect seconds_o = 0 and minutes_o = 1.
   - Expect minute_pulse_o high for exactly one cycle, immediately after the 60th tick.
2. **Setting, wrap without carry, and midnight rollover.**
   - Sequence: mode_i, 23 × inc_i, mode_i, 61 × inc_i, mode_i.
   - Expect hours_o = 23, minutes_o = 1 and state_o = 0 after the final mode_i.
   - Then set minutes to 59 (mode, mode, 58 × inc, mode) and apply 60 ticks.
   - Expect 00:00:00.
3. **Blink and ticks in set mode.** mode_i, then 3 tick_i.
   - Expect blink_o sequence 1 → 0 → 1 → 0.
   - Expect hours, minutes and seconds unchanged.
   - Expect state_o = 1.
4. **Auto-exit.**
   - mode_i, then 30 ticks with no press: expect state_o = 0 the cycle after the 30th tick, and blink_o = 0.
   - Repeat with an inc_i on the same cycle as tick 20: expect exit at tick 50 and hours_o incremented by 1.
5. **Simultaneous events.**
   - mode_i together with inc_i in SET_HOUR: expect state_o = 2 and hours unchanged.
   - tick_i together with mode_i in RUN at seconds = 59: expect state_o = 1, seconds_o = 0, minutes unchanged, and no minute_pulse_o.
6. **Reset mid-operation.** Assert reset_n_i low for 1 cycle while in SET_MIN at 07:42.
   - Expect all outputs 0 and state_o = 0 on the next cycle.
   - A subsequent tick gives seconds_o = 1.
